// File: rtl/score_display_pkg.sv
// Shared constants for the score display: digit count and active-low
// seven-segment patterns ordered {g,f,e,d,c,b,a}.
package score_display_pkg;

  localparam int unsigned NUM_DIGITS = 5;
  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned SCORE_W    = NUM_DIGITS * NIBBLE_W;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  localparam logic [NUM_DIGITS-1:0] AN_OFF = 5'h1F;

endpackage

// File: rtl/score_display_bcd_to_seven_seg.sv
// Combinational BCD nibble to active-low seven-segment decoder.
// Illegal nibbles A..F render as "E" rather than blank so bad data is visible.
module bcd_to_seven_seg
  import score_display_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [SEG_W-1:0]    seg_n
);

  // Nibble to segment lookup
  always_comb begin
    seg_n = SEG_E;
    case (nibble)
      4'd0:    seg_n = SEG_0;
      4'd1:    seg_n = SEG_1;
      4'd2:    seg_n = SEG_2;
      4'd3:    seg_n = SEG_3;
      4'd4:    seg_n = SEG_4;
      4'd5:    seg_n = SEG_5;
      4'd6:    seg_n = SEG_6;
      4'd7:    seg_n = SEG_7;
      4'd8:    seg_n = SEG_8;
      4'd9:    seg_n = SEG_9;
      default: seg_n = SEG_E;
    endcase
  end

endmodule

// File: rtl/score_display.sv
// Five-digit multiplexed seven-segment score display.
// A prescaler paces digit slots; the score is snapshotted once per frame
// (on the last slot) so a frame never shows a mix of old and new digits.
// Optional macro SCORE_DISPLAY_BLANK_EN blanks leading zero digits (digit 0
// is always shown).
module score_display
  import score_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SCORE_W-1:0]    bcd_score,
  output logic [SEG_W-1:0]      seg_n,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  frame_tick
);

  localparam int unsigned CNT_W = 20;
  localparam int unsigned IDX_W = 3;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]      prescaler;
  logic [IDX_W-1:0]      idx;
  logic [SCORE_W-1:0]    snapshot;

  logic                  tick_c;
  logic [NIBBLE_W-1:0]   nibble_c;
  logic [SEG_W-1:0]      seg_c;
  logic [NUM_DIGITS-1:0] an_c;
  logic                  blank_c;

  assign tick_c = (prescaler == CNT_LAST);
  assign an_c   = ~(NUM_DIGITS'(1) << idx);

  // Select the snapshot nibble for the current slot
  always_comb begin
    nibble_c = snapshot[3:0];
    case (idx)
      3'd1:    nibble_c = snapshot[7:4];
      3'd2:    nibble_c = snapshot[11:8];
      3'd3:    nibble_c = snapshot[15:12];
      3'd4:    nibble_c = snapshot[19:16];
      default: nibble_c = snapshot[3:0];
    endcase
  end

  // Leading-zero suppression: slot i blanks when digits i..4 are all zero
  always_comb begin
    blank_c = 1'b0;
`ifdef SCORE_DISPLAY_BLANK_EN
    case (idx)
      3'd1:    blank_c = (snapshot[19:4]  == 16'h0);
      3'd2:    blank_c = (snapshot[19:8]  == 12'h0);
      3'd3:    blank_c = (snapshot[19:12] == 8'h0);
      3'd4:    blank_c = (snapshot[19:16] == 4'h0);
      default: blank_c = 1'b0;
    endcase
`else
    blank_c = 1'b0;
`endif
  end

  bcd_to_seven_seg u_dec (
    .nibble (nibble_c),
    .seg_n  (seg_c)
  );

  // Prescaler, slot index, frame snapshot and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler  <= '0;
      idx        <= '0;
      snapshot   <= '0;
      seg_n      <= SEG_BLANK;
      an_n       <= AN_OFF;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (tick_c) begin
        prescaler <= '0;
        if (idx == IDX_LAST) begin
          idx        <= '0;
          snapshot   <= bcd_score;
          frame_tick <= 1'b1;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end else begin
        prescaler <= prescaler + CNT_W'(1);
      end
      seg_n <= blank_c ? SEG_BLANK : seg_c;
      an_n  <= blank_c ? AN_OFF : an_c;
    end
  end

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: two instances (REFRESH_DIV=4 and 1) share clock,
// reset and score; a cycle-count reference model predicts every output.
module tb_score_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] bcd_score = 20'h0;

  logic [6:0] seg_a, seg_b;
  logic [4:0] an_a, an_b;
  logic       ft_a, ft_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_ft_a = -1;

  // reference model state per instance (0: DIV=4, 1: DIV=1)
  int unsigned m_t[2];
  logic [19:0] m_snap[2];
  logic [6:0]  exp_seg[2];
  logic [4:0]  exp_an[2];
  logic        exp_ft[2];

  always #5 clk = ~clk;

  score_display #(.REFRESH_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .bcd_score(bcd_score),
    .seg_n(seg_a), .an_n(an_a), .frame_tick(ft_a)
  );

  score_display #(.REFRESH_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .bcd_score(bcd_score),
    .seg_n(seg_b), .an_n(an_b), .frame_tick(ft_b)
  );

  function automatic int unsigned div_of(int k);
    return (k == 0) ? 4 : 1;
  endfunction

  // What a given slot should show for a given snapshot: {seg_n, an_n}
  function automatic logic [11:0] ref_display(int unsigned slot, logic [19:0] snap);
    logic [19:0] upper;
    logic [6:0]  seg;
    logic [4:0]  an;
    upper = snap >> (4 * slot);
    case (upper[3:0])
      4'd0: seg = 7'h40;
      4'd1: seg = 7'h79;
      4'd2: seg = 7'h24;
      4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;
      4'd5: seg = 7'h12;
      4'd6: seg = 7'h02;
      4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h10;
      default: seg = 7'h06;
    endcase
    an = ~(5'b00001 << slot);
`ifdef SCORE_DISPLAY_BLANK_EN
    if (slot != 0 && upper == 20'h0) begin
      seg = 7'h7F;
      an  = 5'h1F;
    end
`endif
    return {seg, an};
  endfunction

  // Model: after t edges out of reset, slot = (t/DIV)%5 and a load
  // happens on every edge where t is a multiple of 5*DIV
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_t[k]     = 0;
        m_snap[k]  = 20'h0;
        exp_seg[k] = 7'h7F;
        exp_an[k]  = 5'h1F;
        exp_ft[k]  = 1'b0;
      end else begin
        logic [11:0] r;
        int unsigned d;
        d = div_of(k);
        r = ref_display((m_t[k] / d) % 5, m_snap[k]);
        exp_seg[k] = r[11:5];
        exp_an[k]  = r[4:0];
        m_t[k]     = m_t[k] + 1;
        if (m_t[k] % (5 * d) == 0) begin
          m_snap[k] = bcd_score;
          exp_ft[k] = 1'b1;
        end else begin
          exp_ft[k] = 1'b0;
        end
      end
    end
  end

  task automatic chk7(string tag, logic [6:0] obs, logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk5(string tag, logic [4:0] obs, logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(string tag, int obs, int exp);
    checks++;
    assert (obs == exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
    end
  endtask

  // Advance n cycles, checking both instances on each falling edge
  task automatic run(int n);
    repeat (n) begin
      @(negedge clk);
      cyc++;
      chk7("seg_div4", seg_a, exp_seg[0]);
      chk5("an_div4",  an_a,  exp_an[0]);
      chk1("ft_div4",  ft_a,  exp_ft[0]);
      chk7("seg_div1", seg_b, exp_seg[1]);
      chk5("an_div1",  an_b,  exp_an[1]);
      chk1("ft_div1",  ft_b,  exp_ft[1]);
      if (rst) last_ft_a = -1;
      else if (ft_a) begin
        if (last_ft_a >= 0) chk_int("frame_period_div4", cyc - last_ft_a, 20);
        last_ft_a = cyc;
      end
    end
  endtask

  initial begin
    int n;
    // reset held for three cycles: outputs dark, no frame_tick
    rst = 1'b1;
    run(3);
    chk7("reset_seg", seg_a, 7'h7F);
    chk5("reset_an",  an_a,  5'h1F);

    // static score, two full frames past the first load
    bcd_score = 20'h02048;
    rst = 1'b0;
    run(60);

    // score change mid-frame must wait for the next snapshot
    bcd_score = 20'h00016;
    run(27);
    bcd_score = 20'h00032;
    run(45);

    // all zeros and an illegal nibble
    bcd_score = 20'h00000;
    run(45);
    bcd_score = 20'h0A000;
    run(45);

    // random scores, including illegal nibbles and leading zeros
    repeat (25) begin
      bcd_score = 20'($urandom) >> (4 * $urandom_range(0, 4));
      run($urandom_range(1, 30));
    end

    // reset pulse while the DIV=1 instance sits on slot 3
    n = 0;
    while ((m_t[1] % 5) != 3 && n < 10) begin
      run(1);
      n++;
    end
    chk_int("align_slot3", int'(m_t[1] % 5), 3);
    bcd_score = 20'h98765;
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    n = 0;
    do begin
      run(1);
      n++;
    end while (!ft_b && n < 20);
    chk_int("first_tick_after_rst_div1", n, 5);
    run(50);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
